ir_error_gen: RTL and testbench

IR_ERROR_GEN -- requirements
Module: ir_error_gen

---
 rtl/ir_error_gen.sv | 132 +++++++++++++
 tb/tb_ir_error_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ir_error_gen.sv
// ir_error_gen: IR line-sensor sweep sequencer and weighted position-error generator.
//
// A sweep powers the IR emitter, waits SETTLE_CYC cycles, then converts
// channels 0..7 in order. Each reading is weighted (ch0 -1, ch1 +1, ch2 -2,
// ch3 +2, ch4 -4, ch5 +4, ch6 -8, ch7 +8) and summed. The sum is saturated
// to 16-bit signed and published with a one-cycle err_vld pulse.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   go        level enable; sweeps repeat back-to-back while high
//   a2d_req   one-cycle conversion request strobe (registered)
//   a2d_chnl  channel of the outstanding request
//   a2d_rdy   one-cycle conversion-complete strobe
//   a2d_res   12-bit unsigned reading, valid with a2d_rdy
//   IR_en     IR emitter enable, high during SETTLE/REQ/WAIT (registered)
//   error     signed saturated position error, held between pulses
//   err_vld   one-cycle pulse marking a new error value (registered)
//
// state  | meaning
// IDLE   | emitter off, waiting for go
// SETTLE | emitter on, settle down-counter running
// REQ    | single-cycle conversion request for channel idx
// WAIT   | waiting (no timeout) for a2d_rdy of channel idx
// DONE   | error/err_vld published, emitter off for this cycle
module ir_error_gen #(
   parameter int SETTLE_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   output logic        a2d_req,
   output logic [2:0]  a2d_chnl,
   input  logic        a2d_rdy,
   input  logic [11:0] a2d_res,
   output logic        IR_en,
   output logic [15:0] error,
   output logic        err_vld
);

   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {IDLE, SETTLE, REQ, WAIT, DONE} state_t;

   state_t state, state_nxt;

   logic [CW-1:0]      cnt;
   logic [2:0]         idx;
   logic signed [17:0] acc;

   logic [17:0]        mag;
   logic signed [17:0] term;
   logic signed [17:0] acc_sum;
   logic [15:0]        sat;
   logic               settle_entry;
   logic               take;

   // Weight magnitude is 1,2,4,8 = 1 << idx[2:1]; odd channels add, even subtract.
   always_comb begin
      mag     = {6'd0, a2d_res} << idx[2:1];
      term    = idx[0] ? signed'(mag) : -signed'(mag);
      acc_sum = acc + term;
      if (acc_sum > 18'sd32767)
         sat = 16'h7FFF;
      else if (acc_sum < -18'sd32768)
         sat = 16'h8000;
      else
         sat = acc_sum[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go) state_nxt = SETTLE;
         SETTLE:  if (cnt == '0) state_nxt = REQ;
         REQ:     state_nxt = WAIT;
         WAIT:    if (a2d_rdy) state_nxt = (idx == 3'd7) ? DONE : REQ;
         DONE:    state_nxt = go ? SETTLE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign settle_entry = (state_nxt == SETTLE) && (state != SETTLE);
   // A ready strobe only counts in WAIT; in REQ or elsewhere it is dropped.
   assign take         = (state == WAIT) && a2d_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         idx     <= '0;
         acc     <= '0;
         error   <= '0;
         a2d_req <= 1'b0;
         IR_en   <= 1'b0;
         err_vld <= 1'b0;
      end else begin
         if (settle_entry)
            cnt <= CNT_LOAD;
         else if ((state == SETTLE) && (cnt != '0))
            cnt <= cnt - 1'b1;

         if (settle_entry)
            idx <= '0;
         else if (take && (idx != 3'd7))
            idx <= idx + 1'b1;

         if (settle_entry)
            acc <= '0;
         else if (take)
            acc <= acc_sum;

         // Capture the final sum directly so error is valid alongside err_vld.
         if (take && (idx == 3'd7))
            error <= sat;

         a2d_req <= (state_nxt == REQ);
         IR_en   <= (state_nxt == SETTLE) || (state_nxt == REQ) || (state_nxt == WAIT);
         err_vld <= (state_nxt == DONE);
      end
   end

   assign a2d_chnl = idx;

endmodule

// File: tb/tb_ir_error_gen.sv
// tb_ir_error_gen: directed bench for ir_error_gen with an expected-result
// scoreboard (channel order and final error) and a behavioural A2D responder.
module tb_ir_error_gen;

   localparam int SETTLE_CYC = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   logic        a2d_req;
   logic [2:0]  a2d_chnl;
   logic        a2d_rdy;
   logic [11:0] a2d_res;
   logic        IR_en;
   logic [15:0] error;
   logic        err_vld;

   int checks = 0;
   int errors = 0;

   logic [11:0] rd [8];
   int          w  [8] = '{-1, 1, -2, 2, -4, 4, -8, 8};
   logic [15:0] exp_q [$];
   int          chq [$];

   ir_error_gen #(.SETTLE_CYC(SETTLE_CYC)) dut (
      .clk      (clk),
      .rst      (rst),
      .go       (go),
      .a2d_req  (a2d_req),
      .a2d_chnl (a2d_chnl),
      .a2d_rdy  (a2d_rdy),
      .a2d_res  (a2d_res),
      .IR_en    (IR_en),
      .error    (error),
      .err_vld  (err_vld)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one sweep starting in the first SETTLE cycle.
   // drop_at: channel whose WAIT drops go; rst_at: channel whose WAIT asserts rst;
   // stray: ready pulse during SETTLE; coinc: ready pulse coincident with ch2 request.
   task automatic sweep(input int drop_at, input int rst_at, input bit stray, input bit coinc);
      int          sum;
      int          n;
      int          ir_low;
      logic [15:0] e;
      sum    = 0;
      ir_low = 0;
      for (int i = 0; i < 8; i++) sum += w[i] * int'(rd[i]);
      if (sum > 32767)       e = 16'h7FFF;
      else if (sum < -32768) e = 16'h8000;
      else                   e = 16'(sum);
      if (rst_at < 0) exp_q.push_back(e);
      for (int i = 0; i < 8; i++) chq.push_back(i);

      for (int i = 0; i < 8; i++) begin
         n = 0;
         while (a2d_req !== 1'b1 && n < 200) begin
            if (IR_en !== 1'b1) ir_low++;
            if (stray && i == 0 && n == 3) begin
               a2d_rdy = 1'b1;
               a2d_res = 12'hFFF;
            end
            step();
            a2d_rdy = 1'b0;
            n++;
         end
         if (n >= 200) begin
            check("req_timeout", a2d_req, 1);
            chq.delete();
            return;
         end
         if (i == 0) check("settle_len", n, SETTLE_CYC);
         check("chnl", a2d_chnl, chq.pop_front());
         check("ir_en_req", IR_en, 1);
         if (coinc && i == 2) begin
            a2d_rdy = 1'b1;
            a2d_res = 12'hFFF;
         end
         step();
         a2d_rdy = 1'b0;
         check("req_one_cycle", a2d_req, 0);
         if (i == drop_at) go = 1'b0;
         if (i == rst_at) begin
            go  = 1'b0;
            rst = 1'b1;
            #1;
            check("rst_req", a2d_req, 0);
            check("rst_ir_en", IR_en, 0);
            check("rst_err_vld", err_vld, 0);
            check("rst_chnl", a2d_chnl, 0);
            check("rst_error", error, 0);
            chq.delete();
            step();
            rst = 1'b0;
            return;
         end
         repeat (i % 3) step();
         a2d_rdy = 1'b1;
         a2d_res = rd[i];
         step();
         a2d_rdy = 1'b0;
      end

      check("err_vld_latency", err_vld, 1);
      if (exp_q.size() == 0) check("sb_empty", err_vld, 0);
      else                   check("error", error, exp_q.pop_front());
      check("ir_en_done", IR_en, 0);
      check("ir_en_settle", ir_low, 0);
      step();
      check("err_vld_pulse", err_vld, 0);
      check("error_hold", error, e);
      check("ir_en_after", IR_en, go);
   endtask

   initial begin
      int vld_cnt;
      rst     = 1'b1;
      go      = 1'b0;
      a2d_rdy = 1'b0;
      a2d_res = '0;
      repeat (3) step();
      check("reset_req", a2d_req, 0);
      check("reset_ir_en", IR_en, 0);
      check("reset_err_vld", err_vld, 0);
      check("reset_chnl", a2d_chnl, 0);
      check("reset_error", error, 0);
      rst = 1'b0;
      repeat (4) step();
      check("idle_ir_en", IR_en, 0);
      check("idle_req", a2d_req, 0);

      // All readings equal -> zero error; includes a ready coincident with a request.
      for (int i = 0; i < 8; i++) rd[i] = 12'd100;
      go = 1'b1;
      step();
      check("ir_en_first", IR_en, 1);
      sweep(-1, -1, 1'b0, 1'b1);

      // Back-to-back: ch7 weighted reading, stray ready during SETTLE.
      rd[7] = 12'd1100;
      sweep(-1, -1, 1'b1, 1'b0);

      // Positive saturation.
      for (int i = 0; i < 8; i++) rd[i] = (i % 2 == 1) ? 12'd4095 : 12'd0;
      sweep(-1, -1, 1'b0, 1'b0);

      // Negative saturation, go dropped during ch3 WAIT.
      for (int i = 0; i < 8; i++) rd[i] = (i % 2 == 0) ? 12'd4095 : 12'd0;
      sweep(3, -1, 1'b0, 1'b0);
      repeat (5) step();
      check("post_drop_ir_en", IR_en, 0);
      check("post_drop_req", a2d_req, 0);
      check("post_drop_error", error, 16'h8000);

      // Reset during ch5 WAIT discards the sweep.
      for (int i = 0; i < 8; i++) rd[i] = 12'd100;
      go = 1'b1;
      step();
      sweep(-1, 5, 1'b0, 1'b0);
      vld_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (err_vld === 1'b1) vld_cnt++;
         step();
      end
      check("rst_no_vld", vld_cnt, 0);
      check("rst_error_hold", error, 0);
      check("rst_idle_ir_en", IR_en, 0);

      // Random readings against the reference sum.
      for (int i = 0; i < 8; i++) rd[i] = 12'($urandom_range(0, 4095));
      go = 1'b1;
      step();
      sweep(-1, -1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) rd[i] = 12'($urandom_range(0, 4095));
      sweep(0, -1, 1'b0, 1'b0);
      repeat (3) step();
      check("final_idle_ir_en", IR_en, 0);
      check("sb_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
